// File: rtl/pattern_detector_prog.sv
// Programmable serial pattern detector with a runtime-loaded pattern, length and overlap mode.
// It keeps a history of accepted symbols, flags each match for one cycle and counts matches with saturation.
module pattern_detector_prog #(
    parameter int SYM_W   = 1,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SYM_W-1:0]         d_in,
    input  logic                     valid_in,
    input  logic                     cfg_load,
    input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_overlap,
    output logic                     pattern_flag,
    output logic [CNT_W-1:0]         match_count,
    output logic                     cfg_err
);

    // state | meaning
    // IDLE  | no valid configuration latched since reset or the last bad cfg_load
    // ARMED | valid configuration latched, matching enabled
    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        ARMED = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [MAX_LEN*SYM_W-1:0] hist_q, hist_shift, pat_q;
    logic [LEN_W-1:0]         fill_q, fill_inc, len_q;
    logic                     ovl_q;
    logic                     cfg_ok, accept, pat_eq, match;

    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accept = valid_in && !cfg_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_load && cfg_ok)  state_d = ARMED;
            ARMED:   if (cfg_load && !cfg_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Newest symbol sits at slot 0, so slot i must equal pattern symbol len-1-i.
    always_comb begin
        hist_shift = {hist_q[(MAX_LEN-1)*SYM_W-1:0], d_in};
        fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        pat_eq     = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                if (hist_shift[i*SYM_W +: SYM_W] != pat_q[(int'(len_q) - 1 - i)*SYM_W +: SYM_W])
                    pat_eq = 1'b0;
            end
        end
        match = accept && (state_q == ARMED) && (fill_inc >= len_q) && pat_eq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q       <= '0;
            fill_q       <= '0;
            match_count  <= '0;
            pattern_flag <= 1'b0;
            cfg_err      <= 1'b0;
            pat_q        <= '0;
            len_q        <= '0;
            ovl_q        <= 1'b0;
        end else if (cfg_load) begin
            pat_q        <= cfg_pattern;
            len_q        <= cfg_len;
            ovl_q        <= cfg_overlap;
            cfg_err      <= !cfg_ok;
            hist_q       <= '0;
            fill_q       <= '0;
            match_count  <= '0;
            pattern_flag <= 1'b0;
        end else begin
            pattern_flag <= match;
            if (accept) begin
                hist_q <= hist_shift;
                fill_q <= (match && !ovl_q) ? '0 : fill_inc;
            end
            if (match && (match_count != {CNT_W{1'b1}}))
                match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Bench for pattern_detector_prog: directed scenarios plus randomized streams checked
// against a queue-based model of the matching rules.
module tb_pattern_detector_prog;

    localparam int SYM_W   = 1;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [SYM_W-1:0]         d_in = '0;
    logic                     valid_in = 1'b0;
    logic                     cfg_load = 1'b0;
    logic [MAX_LEN*SYM_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]         cfg_len = '0;
    logic                     cfg_overlap = 1'b0;
    logic                     pattern_flag, pattern_flag2, cfg_err, cfg_err2;
    logic [15:0]              match_count;
    logic [1:0]               match_count2;

    pattern_detector_prog #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .pattern_flag(pattern_flag), .match_count(match_count), .cfg_err(cfg_err)
    );

    pattern_detector_prog #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .pattern_flag(pattern_flag2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    always #5 clk = ~clk;

    // Reference model: accepted symbols since the last clear, oldest first.
    logic [SYM_W-1:0]         m_q[$];
    logic [MAX_LEN*SYM_W-1:0] m_pat = '0;
    int                       m_len = 0;
    bit                       m_ovl = 0;
    bit                       m_armed = 0;
    bit                       m_err = 0;
    bit                       m_flag = 0;
    int                       m_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        chk("flag",   32'(pattern_flag),  32'(m_flag));
        chk("count",  32'(match_count),   32'(m_cnt));
        chk("count2", 32'(match_count2),  32'((m_cnt > 3) ? 3 : m_cnt));
        chk("err",    32'(cfg_err),       32'(m_err));
        chk("flag2",  32'(pattern_flag2), 32'(m_flag));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pat = '0; m_len = 0; m_ovl = 0; m_armed = 0; m_err = 0; m_flag = 0; m_cnt = 0;
    endtask

    // Apply the rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit hit;
        if (cfg_load) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            m_armed = (m_len >= 1) && (m_len <= MAX_LEN);
            m_err = !m_armed; m_q.delete(); m_cnt = 0; m_flag = 0;
        end else if (valid_in) begin
            m_q.push_back(d_in);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            hit = m_armed && (m_q.size() >= m_len);
            if (hit)
                for (int k = 0; k < m_len; k++)
                    if (m_q[m_q.size() - m_len + k] != m_pat[k*SYM_W +: SYM_W]) hit = 0;
            m_flag = hit;
            if (hit) begin
                if (m_cnt < 65535) m_cnt++;
                if (!m_ovl) m_q.delete();
            end
        end else begin
            m_flag = 0;
        end
    endtask

    task automatic tick(input logic v, input logic [SYM_W-1:0] d);
        valid_in = v; d_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic load(input logic [MAX_LEN*SYM_W-1:0] p, input int len, input bit ovl,
                        input logic v, input logic [SYM_W-1:0] d);
        cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_load = 1'b1;
        tick(v, d);
        cfg_load = 1'b0;
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, bits[i]);
    endtask

    initial begin
        // asynchronous reset values, checked between edges
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        // 1,0,0,1,0 non-overlapping
        load(8'b01001, 5, 0, 1'b0, 1'b0);
        feed(32'b01001, 5);
        chk("req029_flag", 32'(pattern_flag), 32'd1);
        chk("req029_cnt",  32'(match_count),  32'd1);
        tick(1'b0, 1'b0);
        chk("req029_flag_drop", 32'(pattern_flag), 32'd0);

        // 1,0,1,0 with and without overlap on 1,0,1,0,1,0
        load(8'b0101, 4, 1, 1'b0, 1'b0);
        feed(32'b010101, 6);
        chk("req030_ovl_cnt", 32'(match_count), 32'd2);
        load(8'b0101, 4, 0, 1'b0, 1'b0);
        feed(32'b010101, 6);
        chk("req030_novl_cnt", 32'(match_count), 32'd1);

        // 1,1,0 with idle gap before the completing symbol
        load(8'b011, 3, 0, 1'b0, 1'b0);
        feed(32'b11, 2);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'($urandom));
        feed(32'b0, 1);
        chk("req031_flag", 32'(pattern_flag), 32'd1);

        // invalid lengths then a valid reload
        load(8'b1, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'($urandom));
        chk("req032_err", 32'(cfg_err), 32'd1);
        chk("req032_cnt", 32'(match_count), 32'd0);
        load(8'b1, MAX_LEN + 1, 1, 1'b0, 1'b0);
        feed(32'hFFFF, 12);
        load(8'b1, 1, 1, 1'b0, 1'b0);
        chk("req032_err_clear", 32'(cfg_err), 32'd0);

        // counter saturation on the 2-bit instance, then load colliding with a match
        feed(32'b11111, 5);
        chk("req033_cnt2", 32'(match_count2), 32'd3);
        load(8'b1, 1, 1, 1'b1, 1'b1);
        chk("req033_load_flag", 32'(pattern_flag), 32'd0);
        chk("req033_load_cnt",  32'(match_count),  32'd0);

        // reset mid-pattern after a completed match
        load(8'b01001, 5, 0, 1'b0, 1'b0);
        feed(32'b01001, 5);
        feed(32'b001, 3);
        #3 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        feed(32'b01001, 5);
        load(8'b01001, 5, 0, 1'b0, 1'b0);
        feed(32'b01, 2);
        chk("req034_no_flag", 32'(pattern_flag), 32'd0);

        // randomized streams; cfg inputs scrambled between loads must be ignored
        for (int r = 0; r < 12; r++) begin
            load(MAX_LEN'($urandom), $urandom_range(1, 5), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < 60; i++) begin
                cfg_pattern = MAX_LEN'($urandom);
                cfg_len = LEN_W'($urandom);
                cfg_overlap = 1'($urandom);
                tick(($urandom_range(0, 3) != 0), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
